// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini CPU: access-size encodings used by the
// memory port and hazard unit, plus the data-port FSM state encoding.
package mini_cpu_pkg;

  localparam logic [1:0] MASK_BYTE = 2'h0;
  localparam logic [1:0] MASK_HALF = 2'h1;
  localparam logic [1:0] MASK_WORD = 2'h2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RMW_RD = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Encodings 2 and 3 both mean a full-word access.
  function automatic logic is_word(input logic [1:0] mask_mode);
    return mask_mode[1];
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational lane merge for sub-word stores: overlays the new byte or
// halfword onto the old memory word, leaving the other lanes untouched.
module store_merge
  import mini_cpu_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  mask_mode,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    if (is_word(mask_mode)) begin
      merged = new_data;
    end else if (mask_mode == MASK_HALF) begin
      // addr_lo[0] is ignored for halfwords
      if (addr_lo[1]) merged[31:16] = new_data[15:0];
      else            merged[15:0]  = new_data[15:0];
    end else begin
      case (addr_lo)
        2'd0:    merged[7:0]   = new_data[7:0];
        2'd1:    merged[15:8]  = new_data[7:0];
        2'd2:    merged[23:16] = new_data[7:0];
        default: merged[31:24] = new_data[7:0];
      endcase
    end
  end

endmodule

// File: rtl/dmem_port_ctrl.sv
// Arbitrates one single-port SRAM between instruction fetch and load/store,
// data first, with a guaranteed fetch slot in every RESP cycle.
module dmem_port_ctrl
  import mini_cpu_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  input  logic [1:0]        dm_maskMode,
  output logic              dm_done,
  output logic [31:0]       dm_rdata,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t state, state_nxt;

  logic              fetch_own;
  logic              op_we;
  logic [1:0]        op_mask;
  logic [1:0]        op_lo;
  logic [MEM_AW-1:0] op_addr;
  logic [31:0]       op_wdata;
  logic [31:0]       merged;

  logic              en_raw, we_raw, gnt_raw;
  logic [MEM_AW-1:0] addr_raw;
  logic [31:0]       wdata_raw;
  logic              start_op;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{dm_addr[31:MEM_AW+2], if_addr[31:MEM_AW+2], if_addr[1:0]};

  assign start_op = (state == ST_IDLE) && dm_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (dm_req) state_nxt = (dm_we && !is_word(dm_maskMode)) ? ST_RMW_RD : ST_RESP;
      end
      ST_RMW_RD: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    en_raw    = 1'b0;
    we_raw    = 1'b0;
    gnt_raw   = 1'b0;
    addr_raw  = '0;
    wdata_raw = '0;
    case (state)
      ST_IDLE: begin
        if (dm_req) begin
          en_raw   = 1'b1;
          addr_raw = dm_addr[MEM_AW+1:2];
          if (dm_we && is_word(dm_maskMode)) begin
            we_raw    = 1'b1;
            wdata_raw = dm_wdata;
          end
        end else if (if_req) begin
          en_raw   = 1'b1;
          gnt_raw  = 1'b1;
          addr_raw = if_addr[MEM_AW+1:2];
        end
      end
      ST_RMW_RD: begin
        en_raw    = 1'b1;
        we_raw    = 1'b1;
        addr_raw  = op_addr;
        wdata_raw = merged;
      end
      ST_RESP: begin
        if (if_req) begin
          en_raw   = 1'b1;
          gnt_raw  = 1'b1;
          addr_raw = if_addr[MEM_AW+1:2];
        end
      end
      default: ;
    endcase
  end

  // The request is captured so an operation finishes even if the core drops it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_we    <= 1'b0;
      op_mask  <= MASK_BYTE;
      op_lo    <= 2'd0;
      op_addr  <= '0;
      op_wdata <= '0;
    end else if (start_op) begin
      op_we    <= dm_we;
      op_mask  <= dm_maskMode;
      op_lo    <= dm_addr[1:0];
      op_addr  <= dm_addr[MEM_AW+1:2];
      op_wdata <= dm_wdata;
    end
  end

  // Owner of the read data returning next cycle: 1 = fetch, 0 = data port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fetch_own <= 1'b0;
    else       fetch_own <= gnt_raw;
  end

  store_merge u_store_merge (
    .old_word  (mem_rdata),
    .new_data  (op_wdata),
    .addr_lo   (op_lo),
    .mask_mode (op_mask),
    .merged    (merged)
  );

  assign mem_en    = en_raw & ~reset;
  assign mem_we    = we_raw & ~reset;
  assign mem_addr  = reset ? '0 : addr_raw;
  assign mem_wdata = reset ? '0 : wdata_raw;
  assign if_gnt    = gnt_raw & ~reset;

  assign if_rvalid = fetch_own & ~reset;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_done   = (state == ST_RESP) & ~reset;
  assign dm_rdata  = (dm_done && !op_we && !fetch_own) ? mem_rdata : '0;
  assign dm_stall  = dm_req & ~dm_done & ~reset;

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Directed bench for dmem_port_ctrl with a behavioural synchronous SRAM.
module tb_dmem_port_ctrl;

  localparam int MEM_AW = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt, if_rvalid;
  logic [31:0]       if_rdata;
  logic              dm_req, dm_we;
  logic [31:0]       dm_addr, dm_wdata;
  logic [1:0]        dm_maskMode;
  logic              dm_done, dm_stall;
  logic [31:0]       dm_rdata;
  logic              mem_en, mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;

  logic              pre_we = 1'b0;
  logic [MEM_AW-1:0] pre_addr = '0;
  logic [31:0]       pre_dat = '0;
  logic [31:0]       mem [0:(1<<MEM_AW)-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_port_ctrl #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_maskMode(dm_maskMode), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_dat;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [MEM_AW-1:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_dat = d;
    cyc();
    pre_we = 1'b0;
  endtask

  int gnts, dones, waits, max_wait;

  initial begin
    reset = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0;
    dm_addr = 0; dm_wdata = 0; dm_maskMode = 0;
    cyc();

    // outputs forced low while reset is held, even with live requests
    if_req = 1; if_addr = 32'h20; dm_req = 1; dm_we = 1; dm_addr = 32'h10; dm_maskMode = 2;
    #1;
    chk("rst_gnt", {31'b0, if_gnt}, 0);
    chk("rst_en", {31'b0, mem_en}, 0);
    chk("rst_we", {31'b0, mem_we}, 0);
    chk("rst_stall", {31'b0, dm_stall}, 0);
    chk("rst_done", {31'b0, dm_done}, 0);
    chk("rst_rvalid", {31'b0, if_rvalid}, 0);
    if_req = 0; dm_req = 0;
    preload(10'd4, 32'h0);
    preload(10'd5, 32'h11223344);
    preload(10'd6, 32'h0);
    preload(10'd7, 32'h55667788);
    preload(10'd8, 32'hCAFEF00D);

    // first fetch immediately after reset release
    reset = 0; if_req = 1; if_addr = 32'h20;
    #1;
    chk("fetch0_gnt", {31'b0, if_gnt}, 1);
    chk("fetch0_addr", {22'b0, mem_addr}, 8);
    cyc(); if_req = 0; #1;
    chk("fetch0_rvalid", {31'b0, if_rvalid}, 1);
    chk("fetch0_rdata", if_rdata, 32'hCAFEF00D);
    chk("fetch0_gnt_off", {31'b0, if_gnt}, 0);
    cyc(); #1;
    chk("fetch0_rvalid_off", {31'b0, if_rvalid}, 0);

    // word store
    dm_req = 1; dm_we = 1; dm_addr = 32'h10; dm_wdata = 32'hDEADBEEF; dm_maskMode = 2;
    #1;
    chk("ws_we", {31'b0, mem_we}, 1);
    chk("ws_addr", {22'b0, mem_addr}, 4);
    chk("ws_wdata", mem_wdata, 32'hDEADBEEF);
    chk("ws_stall0", {31'b0, dm_stall}, 1);
    cyc(); #1;
    chk("ws_done", {31'b0, dm_done}, 1);
    chk("ws_stall1", {31'b0, dm_stall}, 0);
    chk("ws_mem", mem[4], 32'hDEADBEEF);
    dm_req = 0;
    cyc();

    // second word store (mask 3) sets up the byte-store target
    dm_req = 1; dm_we = 1; dm_addr = 32'h10; dm_wdata = 32'h11223344; dm_maskMode = 3;
    #1;
    chk("ws3_we", {31'b0, mem_we}, 1);
    cyc(); #1;
    chk("ws3_done", {31'b0, dm_done}, 1);
    dm_req = 0;
    cyc();
    chk("ws3_mem", mem[4], 32'h11223344);

    // byte store, lane 2
    dm_req = 1; dm_we = 1; dm_addr = 32'h12; dm_wdata = 32'h000000AA; dm_maskMode = 0;
    #1;
    chk("bs_rd_en", {31'b0, mem_en}, 1);
    chk("bs_rd_we", {31'b0, mem_we}, 0);
    chk("bs_rd_addr", {22'b0, mem_addr}, 4);
    chk("bs_stall0", {31'b0, dm_stall}, 1);
    cyc(); #1;
    chk("bs_wr_we", {31'b0, mem_we}, 1);
    chk("bs_wr_data", mem_wdata, 32'h11AA3344);
    chk("bs_stall1", {31'b0, dm_stall}, 1);
    chk("bs_done_early", {31'b0, dm_done}, 0);
    cyc(); #1;
    chk("bs_done", {31'b0, dm_done}, 1);
    chk("bs_stall2", {31'b0, dm_stall}, 0);
    dm_req = 0;
    cyc();
    chk("bs_mem", mem[4], 32'h11AA3344);

    // half store, bit0 ignored; request dropped and inputs scrambled mid-op
    dm_req = 1; dm_we = 1; dm_addr = 32'h17; dm_wdata = 32'h0000BEEF; dm_maskMode = 1;
    #1;
    chk("hs_rd_addr", {22'b0, mem_addr}, 5);
    cyc();
    dm_req = 0; dm_addr = 32'h40; dm_wdata = 32'h12345678; dm_maskMode = 2;
    #1;
    chk("hs_wr_we", {31'b0, mem_we}, 1);
    chk("hs_wr_addr", {22'b0, mem_addr}, 5);
    chk("hs_wr_data", mem_wdata, 32'hBEEF3344);
    cyc(); #1;
    chk("hs_done", {31'b0, dm_done}, 1);
    chk("hs_stall", {31'b0, dm_stall}, 0);
    cyc();
    chk("hs_mem", mem[5], 32'hBEEF3344);

    // back-to-back byte stores with a constant fetch request
    gnts = 0; dones = 0; waits = 0; max_wait = 0;
    dm_req = 1; dm_we = 1; dm_maskMode = 0; if_req = 1; if_addr = 32'h20;
    for (int k = 0; k < 4; k++) begin
      dm_addr = 32'h18 + k;
      dm_wdata = 32'hFFFFFF00 | (k + 1);
      for (int c = 0; c < 3; c++) begin
        #1;
        if (if_gnt) gnts++;
        if (dm_done) dones++;
        if (if_req && !if_gnt) waits++;
        else waits = 0;
        if (waits > max_wait) max_wait = waits;
        if (k == 3 && c == 2) dm_req = 0;
        cyc();
      end
    end
    if_req = 0;
    chk("b2b_gnts", gnts, 4);
    chk("b2b_dones", dones, 4);
    chk("b2b_max_wait", max_wait, 2);
    chk("b2b_mem", mem[6], 32'h04030201);

    // contention: load wins, fetch takes the RESP slot
    dm_req = 1; dm_we = 0; dm_addr = 32'h10; dm_maskMode = 2; if_req = 1; if_addr = 32'h20;
    #1;
    chk("ct_en", {31'b0, mem_en}, 1);
    chk("ct_we", {31'b0, mem_we}, 0);
    chk("ct_addr", {22'b0, mem_addr}, 4);
    chk("ct_gnt0", {31'b0, if_gnt}, 0);
    cyc(); #1;
    chk("ct_done", {31'b0, dm_done}, 1);
    chk("ct_rdata", dm_rdata, 32'h11AA3344);
    chk("ct_gnt1", {31'b0, if_gnt}, 1);
    chk("ct_faddr", {22'b0, mem_addr}, 8);
    dm_req = 0;
    cyc(); if_req = 0; #1;
    chk("ct_rvalid", {31'b0, if_rvalid}, 1);
    chk("ct_frdata", if_rdata, 32'hCAFEF00D);
    chk("ct_done_off", {31'b0, dm_done}, 0);
    cyc();

    // reset in RMW_RD aborts the store
    dm_req = 1; dm_we = 1; dm_addr = 32'h1C; dm_wdata = 32'h00000099; dm_maskMode = 0;
    if_req = 1; if_addr = 32'h20;
    #1;
    chk("ab_rd_addr", {22'b0, mem_addr}, 7);
    cyc();
    reset = 1;
    #1;
    chk("ab_we", {31'b0, mem_we}, 0);
    chk("ab_en", {31'b0, mem_en}, 0);
    chk("ab_gnt", {31'b0, if_gnt}, 0);
    chk("ab_stall", {31'b0, dm_stall}, 0);
    chk("ab_done", {31'b0, dm_done}, 0);
    chk("ab_maddr", {22'b0, mem_addr}, 0);
    chk("ab_wdata", mem_wdata, 0);
    cyc(); #1;
    chk("ab_done_rst", {31'b0, dm_done}, 0);
    dm_req = 0; if_req = 0; reset = 0;
    cyc(); #1;
    chk("ab_done_after", {31'b0, dm_done}, 0);
    chk("ab_mem", mem[7], 32'h55667788);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_port_ctrl.md
DMEM_PORT_CTRL -- requirements
Module: dmem_port_ctrl

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, memory word-address width (4 KiB unified memory).
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
  clk  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-high reset
  if_req  in  1  fetch request
  if_addr  in  32  fetch byte address
  if_gnt  out  1  fetch issued to memory this cycle
  if_rvalid  out  1  fetch data valid
  if_rdata  out  32  fetch data
  dm_req  in  1  load/store request, held until dm_done
  dm_we  in  1  1 = store, 0 = load
  dm_addr  in  32  data byte address
  dm_wdata  in  32  store data, right-aligned
  dm_maskMode  in  2  0 byte, 1 half, 2 or 3 word
  dm_done  out  1  one-cycle completion pulse
  dm_rdata  out  32  raw load word, valid with dm_done
  dm_stall  out  1  pipeline stall to the hazard unit
  mem_en, mem_we  out  1 each  single-port synchronous SRAM strobe and write enable
  mem_addr  out  MEM_AW  word address = addr[MEM_AW+1:2]
  mem_wdata  out  32  write word
  mem_rdata  in  32  read word, valid the cycle after a read strobe
REQ-003 SHALL use one clock, clk; reset SHALL be asynchronous and active-high, named reset.

Function
REQ-004 SHALL implement FSM states IDLE, RMW_RD, RESP.
REQ-005 In IDLE with dm_req=1, the block SHALL serve data, which has priority over fetch. Transitions:
  - Load: read strobe, then RESP.
  - Word store: write strobe with mem_wdata = dm_wdata, then RESP.
  - Byte/half store: read strobe, then RMW_RD.
REQ-006 RMW_RD SHALL merge into mem_rdata and issue the write in the same cycle, then go to RESP.
  - Byte: lane dm_addr[1:0] takes dm_wdata[7:0].
  - Half: lane dm_addr[1] takes dm_wdata[15:0], with dm_addr[0] ignored.
  - Other lanes are unchanged.
REQ-007 RESP SHALL pulse dm_done for one cycle. For loads it SHALL drive dm_rdata = mem_rdata. It SHALL then return to IDLE.
REQ-008 Latency, request to dm_done: load and word store 1 cycle; byte/half store 2 cycles.
REQ-009 dm_stall SHALL equal dm_req & ~dm_done.
REQ-010 Fetch SHALL be granted (if_gnt=1, read strobe on if_addr) only in two cases:
  - IDLE with dm_req=0 and if_req=1.
  - RESP with if_req=1, since the port is free in RESP.
REQ-011 if_rvalid SHALL assert exactly one cycle after if_gnt, with if_rdata = mem_rdata.
REQ-012 Fetch SHALL never starve: every RESP cycle offers a fetch slot.
REQ-013 Simultaneous if_req and dm_req in IDLE: data SHALL win, and fetch SHALL wait for the RESP slot.
REQ-014 Once started, an operation SHALL complete even if dm_req drops. No new data operation SHALL start in RESP.
REQ-015 At most one memory strobe SHALL occur per cycle.
REQ-016 Read ownership SHALL be tracked by a registered owner bit that steers mem_rdata.
REQ-017 mem_* and if_gnt SHALL be combinational from state and inputs. dm_done and if_rvalid SHALL be registered-state decodes.

Reset
REQ-018 While reset=1, state SHALL be IDLE and the owner bit cleared.
REQ-019 While reset=1, all outputs SHALL be 0.
REQ-020 Reset during RMW_RD or RESP SHALL abort without any memory write and without a dm_done pulse.
REQ-021 The first grant SHALL be possible on the first clk edge after reset deasserts.

Structure
REQ-022 The shared mini_cpu package SHALL hold MASK_BYTE=2'h0, MASK_HALF=2'h1, MASK_WORD=2'h2 (also used by the hazard unit) and the FSM state encoding.
REQ-023 Lane merge SHALL be a combinational sub-module store_merge (inputs old word, new data, addr[1:0], maskMode; output merged word).

Verification
REQ-024 Word store: addr 0x10, wdata 0xDEADBEEF -> cycle0 mem_we=1, mem_addr=4; cycle1 dm_done=1; memory word 4 = 0xDEADBEEF.
REQ-025 Byte store over 0x11223344: addr 0x12, wdata 0xAA -> read strobe, then write 0x11AA3344; dm_done 2 cycles after request; dm_stall high for 2 cycles.
REQ-026 Half store: addr 0x17 (bit0 ignored), wdata 0xBEEF over 0x11223344 at word 5 -> write 0xBEEF3344.
REQ-027 Contention: if_req and dm_req load at cycle0 -> load strobed cycle0; fetch granted cycle1 (RESP); if_rvalid cycle2; dm_done cycle1.
REQ-028 Continuous back-to-back byte stores plus constant if_req -> one if_gnt per store; no fetch waits longer than 3 cycles.
REQ-029 Reset asserted in RMW_RD -> no mem_we, all outputs 0 immediately, target word unchanged.
